// File: rtl/sramif_fifo_pf.sv
// sramif_fifo_pf: show-ahead FIFO for the SRAM-interface pipelines.
// Arbitrary depth, exact occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and a high-water-mark monitor.
module sramif_fifo_pf #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 6,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    input  logic [CNT_W-1:0] afull_thr,
    input  logic [CNT_W-1:0] aempty_thr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-1:0] max_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;

    // Status flags straight from the registered count and live thresholds
    always_comb begin
        full         = (count_q == FULL_CNT);
        empty        = (count_q == '0);
        almost_full  = (count_q >= afull_thr);
        almost_empty = (count_q <= aempty_thr);
    end

    // Acceptance on current state; flush swallows both requests
    always_comb begin
        wr_acc = write & ~full & ~flush;
        rd_acc = read & ~empty & ~flush;
    end

    // Next-state for pointers, count, error flags and high-water mark
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        max_d    = max_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            max_d    = '0;
        end else begin
            // Explicit wrap so non-power-of-2 depths work
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_W'(1);
            end
            // A new error event beats a same-cycle clear
            if (write && full) begin
                ovf_d = 1'b1;
            end else if (err_clr) begin
                ovf_d = 1'b0;
            end
            if (read && empty) begin
                unf_d = 1'b1;
            end else if (err_clr) begin
                unf_d = 1'b0;
            end
            if (count_d > max_q) begin
                max_d = count_d;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            max_q    <= max_d;
        end
    end

    // Storage array; flush leaves contents in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Show-ahead head entry and registered outputs
    always_comb begin
        data_out  = mem_q[rd_ptr_q];
        count     = count_q;
        overflow  = ovf_q;
        underflow = unf_q;
        max_level = max_q;
    end

endmodule

// File: tb/tb_sramif_fifo_pf.sv
// Self-checking bench for sramif_fifo_pf: vector table plus data scoreboard,
// followed by hand-written threshold, flush and mid-burst reset sequences.
module tb_sramif_fifo_pf;

    localparam int WIDTH = 128;
    localparam int DEPTH = 6;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, write, read, err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] afull_thr, aempty_thr;
    logic [CNT_W-1:0] count, max_level;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;

    sramif_fifo_pf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .write        (write),
        .data_in      (data_in),
        .read         (read),
        .data_out     (data_out),
        .afull_thr    (afull_thr),
        .aempty_thr   (aempty_thr),
        .err_clr      (err_clr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .max_level    (max_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       wr;
        bit       rd;
        bit       ec;
        bit [7:0] din;
        int       cnt;
        bit       ful;
        bit       emp;
        bit       ovf;
        bit       unf;
        int       mx;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb[$];
    int               tests = 0;
    int               fails = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit wr, input bit rd, input bit ec, input bit [7:0] din,
                       input int cnt, input bit ful, input bit emp, input bit ovf,
                       input bit unf, input int mx);
        vec_t v;
        v = '{wr, rd, ec, din, cnt, ful, emp, ovf, unf, mx};
        vecs.push_back(v);
    endtask

    // One clock: scoreboard check/update, drive, edge, settle. Called at posedge+1.
    task automatic do_cycle(input bit wr, input bit rd, input bit fl, input bit ec,
                            input bit [7:0] din);
        logic [WIDTH-1:0] exp_d;
        bit               wacc, racc;
        wacc = wr && !fl && (sb.size() < DEPTH);
        racc = rd && !fl && (sb.size() > 0);
        if (racc) begin
            exp_d = sb.pop_front();
            chk("data_out", data_out, exp_d);
        end
        if (wacc) sb.push_back({{(WIDTH-8){1'b0}}, din});
        if (fl) sb.delete();
        write   = wr;
        read    = rd;
        flush   = fl;
        err_clr = ec;
        data_in = {{(WIDTH-8){1'b0}}, din};
        @(posedge clk);
        #1;
        write   = 1'b0;
        read    = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_max"}, max_level, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_unf"}, underflow, 0);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_afull"}, almost_full, afull_thr == 0);
    endtask

    initial begin
        // Table: hand-derived expectations for DEPTH = 6
        for (int i = 0; i < 6; i++) add(1, 0, 0, 8'hA0 + 8'(i), i + 1, i == 5, 0, 0, 0, i + 1);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 8'h00, 5 - i, 0, i == 5, 0, 0, 6);
        // Wrap-around
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'hB0 + 8'(i), i + 1, 0, 0, 0, 0, 6);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 8'h00, 3 - i, 0, i == 3, 0, 0, 6);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 8'hC0 + 8'(i), i + 1, i == 5, 0, 0, 0, 6);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 8'h00, 5 - i, 0, i == 5, 0, 0, 6);
        // Full with write+read: write dropped, overflow set
        for (int i = 0; i < 6; i++) add(1, 0, 0, 8'hD0 + 8'(i), i + 1, i == 5, 0, 0, 0, 6);
        add(1, 1, 0, 8'hEE, 5, 0, 0, 1, 0, 6);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h00, 4 - i, 0, i == 4, 1, 0, 6);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 6);
        // Empty with write+read: read dropped, underflow set, write accepted
        add(1, 1, 0, 8'hF0, 1, 0, 0, 0, 1, 6);
        add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 6);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 6);
        // Same-cycle clear and new underflow: set wins
        add(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 6);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 6);

        rst_n      = 1'b0;
        flush      = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        err_clr    = 1'b0;
        data_in    = '0;
        afull_thr  = 3'd7;
        aempty_thr = 3'd0;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            do_cycle(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].ec, vecs[i].din);
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_full", i), full, vecs[i].ful);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].emp);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("v%0d_unf", i), underflow, vecs[i].unf);
            chk($sformatf("v%0d_max", i), max_level, vecs[i].mx);
        end

        // Thresholds: almost_full at >=4, almost_empty at <=1
        afull_thr  = 3'd4;
        aempty_thr = 3'd1;
        #1;
        chk("thr_af0", almost_full, 0);
        chk("thr_ae0", almost_empty, 1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, 0, 0, 0, 8'h50 + 8'(i));
            chk($sformatf("thr_af%0d", i + 1), almost_full, (i + 1) >= 4);
            chk($sformatf("thr_ae%0d", i + 1), almost_empty, (i + 1) <= 1);
        end
        afull_thr = 3'd5;
        #1;
        chk("thr_af_change", almost_full, 0);
        // Threshold above DEPTH keeps almost_full low even when full
        afull_thr = 3'd7;
        do_cycle(1, 0, 0, 0, 8'h54);
        do_cycle(1, 0, 0, 0, 8'h55);
        chk("thr_full", full, 1);
        chk("thr_af_above_depth", almost_full, 0);
        afull_thr = 3'd6;
        #1;
        chk("thr_af_eq_depth", almost_full, 1);

        // Flush at count 3 with write and read asserted
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 0, 8'h00);
        chk("pre_flush_count", count, 3);
        do_cycle(1, 1, 1, 0, 8'h77);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_max", max_level, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_unf", underflow, 0);
        // Flush while empty with read: no underflow
        do_cycle(0, 1, 1, 0, 8'h00);
        chk("flush_empty_unf", underflow, 0);
        do_cycle(1, 0, 0, 0, 8'h61);
        chk("post_flush_count", count, 1);
        chk("post_flush_max", max_level, 1);
        do_cycle(1, 0, 0, 0, 8'h62);

        // Asynchronous reset mid-burst
        afull_thr = 3'd5;
        write     = 1'b1;
        data_in   = {{(WIDTH-8){1'b0}}, 8'h63};
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        afull_thr = 3'd0;
        #1;
        chk("async_rst_af_thr0", almost_full, 1);
        write = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(1, 0, 0, 0, 8'h71);
        do_cycle(0, 1, 0, 0, 8'h00);
        chk("after_rst_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sramif_fifo_pf.md
Name: sramif_fifo_pf

Overview:
- Parametrised successor to the SRAM-interface buffer FIFO.
- Supports arbitrary (non-power-of-2) depth, an exact occupancy count, run-time programmable almost-full/almost-empty thresholds, protected push/pop, sticky overflow/underflow error flags and a high-water-mark monitor.
- Sits between the SRAM-interface request/response pipelines and the bus side, absorbing bursts.
- Data output is show-ahead: the head entry is visible without a read.

Parameters:
- WIDTH, 128, entry width in bits.
- DEPTH, 6, number of entries; any integer >= 2, not restricted to powers of 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy/threshold/level fields (derived, not overridden).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of contents, pointers, flags, high-water mark.
- write  input  1  push request.
- data_in  input  WIDTH  push data.
- read  input  1  pop request.
- data_out  output  WIDTH  head entry (show-ahead).
- afull_thr  input  CNT_W  almost-full threshold.
- aempty_thr  input  CNT_W  almost-empty threshold.
- err_clr  input  1  clears sticky error flags.
- count  output  CNT_W  current occupancy 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= afull_thr.
- almost_empty  output  1  count <= aempty_thr.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- max_level  output  CNT_W  highest count reached since reset/flush.

Behaviour:
- Reset (rst_n low, async):
  - pointers, count, overflow, underflow, max_level = 0; all memory entries = 0.
  - Outputs: empty=1, full=0, data_out=0, almost_full=(afull_thr==0), almost_empty=1.
  - Reset asserted mid-operation discards all contents immediately.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide.
  - Each increments modulo DEPTH: DEPTH-1 wraps to 0 explicitly, never by binary overflow.
  - Full/empty are derived from count, not from pointer compare.
- Acceptance:
  - wr_acc = write & ~full; rd_acc = read & ~empty, both evaluated on current-cycle state.
  - When full, write is dropped even if read is accepted in the same cycle.
  - When empty, read is dropped and a simultaneous write is accepted.
- Count update:
  - count += 1 on wr_acc only; count -= 1 on rd_acc only; unchanged when both or neither are accepted.
  - Never leaves 0..DEPTH.
- Memory:
  - On wr_acc, mem[wr_ptr] <= data_in at the clock edge.
  - data_out = mem[rd_ptr] combinationally.
  - Write-to-read latency is 1 cycle: pushed data is visible on data_out the cycle after the push when the FIFO was empty.
  - Contents are undefined-but-stable after pop; the bench must not check data_out while empty.
- Flags:
  - full, empty, almost_full, almost_empty are combinational from the registered count and the threshold inputs.
  - Threshold changes take effect the same cycle.
  - afull_thr > DEPTH keeps almost_full low.
- Errors:
  - overflow sets on (write & full); underflow sets on (read & empty).
  - Both are sticky until err_clr or flush.
  - If err_clr and a new error event occur in the same cycle, set wins.
- max_level:
  - Registered; updates to next count when next count > max_level.
- Flush:
  - Highest priority below reset.
  - Zeroes pointers, count, overflow, underflow, max_level next edge; memory contents are retained.
  - write and read in the flush cycle are ignored and raise no error flags.

Test Plan:
- Reset, then push 0xA0..0xA5 (DEPTH=6) -> count 1..6, full=1 after sixth push, max_level=6; pop six -> data_out sequence A0..A5, empty=1.
- Wrap-around: push 4, pop 4, push 6, pop 6 -> pointers wrap at 5->0, data order preserved, no errors.
- Full with simultaneous write+read -> write dropped, overflow=1, count=5, dropped data never appears; err_clr -> overflow=0.
- Empty with simultaneous write+read -> underflow=1, count=1, data_out=pushed value next cycle.
- Thresholds afull_thr=4, aempty_thr=1: push to 4 -> almost_full rises on fourth push, almost_empty falls at count 2; change afull_thr=5 at count 4 -> almost_full drops same cycle.
- Flush at count 3 with write/read asserted -> count 0, empty=1, max_level=0, no error flags; rst_n pulse mid-burst -> all outputs at reset values asynchronously.
